// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : addsub_pkg
// Brief   : Shared FSM state type and saturation constants for seq_addsub.
// Revision: 1.0
// ============================================================================
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MAX_WIDTH = 64;

  // Largest positive two's complement value: 0 followed by all 1s.
  function automatic logic [MAX_WIDTH-1:0] sat_max_pos(input int unsigned width);
    return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
  endfunction

  // Most negative two's complement value: 1 followed by all 0s.
  function automatic logic [MAX_WIDTH-1:0] sat_min_neg(input int unsigned width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// Module  : addsub_slice
// Brief   : Combinational W-bit ripple adder slice, also exposing carry into MSB.
// Revision: 1.0
// ============================================================================
module addsub_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  always_comb begin
    logic [W:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
    cout = c[W];
    cmsb = c[W-1];
  end

endmodule
`default_nettype wire

// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
// Module  : seq_addsub
// Brief   : Digit-serial add/subtract with optional signed saturation.
// Revision: 1.0
// ============================================================================
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0 || WIDTH > MAX_WIDTH) begin : g_param_check
    $error("seq_addsub: DIGIT must be >= 1 and divide WIDTH (WIDTH <= 64)");
  end

  localparam int c_n     = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
  localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(c_n - 1);
  localparam logic [WIDTH-1:0]   c_max_pos = WIDTH'(sat_max_pos(WIDTH));
  localparam logic [WIDTH-1:0]   c_min_neg = WIDTH'(sat_min_neg(WIDTH));

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_a_msb;
  logic                 r_sub;
  logic                 r_sat;
  logic                 r_cin;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_sum;
  logic [WIDTH-1:0]     r_result;
  logic                 r_carry;
  logic                 r_ovf;
  logic                 r_zero;
  logic                 r_neg;

  logic [DIGIT-1:0]     w_b_slice;
  logic [DIGIT-1:0]     w_slice_sum;
  logic                 w_slice_cout;
  logic                 w_slice_cmsb;
  logic                 w_last;
  logic                 w_ovf;
  logic [WIDTH-1:0]     w_sum_next;
  logic [WIDTH-1:0]     w_final;

  // Operands shift right each cycle so the active slice is always at the LSBs.
  assign w_b_slice = r_sub ? ~r_b[DIGIT-1:0] : r_b[DIGIT-1:0];

  addsub_slice #(.W(DIGIT)) u_slice (
    .x    (r_a[DIGIT-1:0]),
    .y    (w_b_slice),
    .cin  (r_cin),
    .sum  (w_slice_sum),
    .cout (w_slice_cout),
    .cmsb (w_slice_cmsb)
  );

  assign w_last     = (r_cnt == c_last);
  assign w_sum_next = (r_sum >> DIGIT) | (WIDTH'(w_slice_sum) << (WIDTH - DIGIT));
  assign w_ovf      = w_slice_cmsb ^ w_slice_cout;
  assign w_final    = (r_sat && w_ovf) ? (r_a_msb ? c_min_neg : c_max_pos) : w_sum_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_a_msb  <= 1'b0;
      r_sub    <= 1'b0;
      r_sat    <= 1'b0;
      r_cin    <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_a     <= a;
        r_b     <= b;
        r_a_msb <= a[WIDTH-1];
        r_sub   <= sub;
        r_sat   <= sat;
        r_cin   <= sub;
        r_cnt   <= '0;
      end
    end else if (r_state == RUN) begin
      r_a   <= r_a >> DIGIT;
      r_b   <= r_b >> DIGIT;
      r_cin <= w_slice_cout;
      r_cnt <= r_cnt + c_cnt_w'(1);
      r_sum <= w_sum_next;
      // Flags are registered so they stay frozen through DONE and the following IDLE.
      if (w_last) begin
        r_result <= w_final;
        r_carry  <= w_slice_cout;
        r_ovf    <= w_ovf;
        r_zero   <= (w_final == '0);
        r_neg    <= w_final[WIDTH-1];
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign negative  = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_addsub
// Brief   : Scoreboard bench for seq_addsub at DIGIT = 4, 16 and 1.
// Revision: 1.0
// ============================================================================
module tb_seq_addsub;

  localparam int DIG [3] = '{4, 16, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid [3];
  logic        in_ready [3];
  logic [15:0] a [3];
  logic [15:0] b [3];
  logic        sub [3];
  logic        sat [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] result [3];
  logic        carry [3];
  logic        overflow [3];
  logic        zero [3];
  logic        negative [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    seq_addsub #(.WIDTH(16), .DIGIT(DIG[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g]),
      .b         (b[g]),
      .sub       (sub[g]),
      .sat       (sat[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .result    (result[g]),
      .carry     (carry[g]),
      .overflow  (overflow[g]),
      .zero      (zero[g]),
      .negative  (negative[g])
    );
  end

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic s, input logic st);
    exp_t        e;
    logic [15:0] yy;
    logic [16:0] full;
    yy    = s ? ~y : y;
    full  = {1'b0, x} + {1'b0, yy} + {16'd0, s};
    e.res = full[15:0];
    e.c   = full[16];
    e.v   = (x[15] == yy[15]) && (full[15] != x[15]);
    if (st && e.v) e.res = x[15] ? 16'h8000 : 16'h7FFF;
    e.z   = (e.res == 16'h0000);
    e.n   = e.res[15];
    return e;
  endfunction

  function automatic exp_t obs(input int d);
    return {result[d], carry[d], overflow[d], zero[d], negative[d]};
  endfunction

  // Ends on the falling edge right after the acceptance edge.
  task automatic start_op(input int d, input logic [15:0] x, input logic [15:0] y,
                          input logic s, input logic st);
    exp_q.push_back(model(x, y, s, st));
    @(negedge clk);
    a[d] = x; b[d] = y; sub[d] = s; sat[d] = st; in_valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output int cyc);
    cyc = 0;
    while (out_valid[d] !== 1'b1 && cyc < 64) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid[0] = 1'b1;
    a[0] = 16'h1111;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({out_valid[d], in_ready[d], obs(d)} !== {1'b1 ^ 1'b1, 1'b1, 20'h0}) begin
        failures++;
        $display("FAIL reset_state dut%0d: got ov=%b ir=%b out=%h expected ov=0 ir=1 out=0",
                 d, out_valid[d], in_ready[d], obs(d));
      end
    end
    in_valid[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready[0], out_valid[0]} !== 2'b10) begin
      failures++;
      $display("FAIL reset_no_accept: got ir=%b ov=%b expected ir=1 ov=0", in_ready[0], out_valid[0]);
    end
  endtask

  task automatic test_arith(input int d);
    logic [33:0] vec [5] = '{
      {16'h7FFF, 16'h0001, 1'b0, 1'b0},
      {16'h7FFF, 16'h0001, 1'b0, 1'b1},
      {16'h8000, 16'h0001, 1'b1, 1'b1},
      {16'h0005, 16'h0005, 1'b1, 1'b0},
      {16'h0000, 16'h0001, 1'b1, 1'b0}
    };
    int   cyc;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      start_op(d, vec[i][33:18], vec[i][17:2], vec[i][1], vec[i][0]);
      wait_done(d, cyc);
      e = exp_q.pop_front();
      checks++;
      if (cyc !== 16 / DIG[d]) begin
        failures++;
        $display("FAIL latency dut%0d vec%0d: got %0d expected %0d", d, i, cyc, 16 / DIG[d]);
      end
      checks++;
      if (obs(d) !== e) begin
        failures++;
        $display("FAIL arith dut%0d vec%0d: got res/c/v/z/n=%h expected %h", d, i, obs(d), e);
      end
      finish_op(d);
      checks++;
      if ({out_valid[d], in_ready[d], obs(d)} !== {2'b01, e}) begin
        failures++;
        $display("FAIL idle_hold dut%0d vec%0d: got ov=%b ir=%b out=%h expected ov=0 ir=1 out=%h",
                 d, i, out_valid[d], in_ready[d], obs(d), e);
      end
    end
  endtask

  task automatic test_hold();
    int   cyc;
    exp_t e;
    start_op(0, 16'h1234, 16'h0F0F, 1'b0, 1'b0);
    wait_done(0, cyc);
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid[0], in_ready[0], obs(0)} !== {2'b10, e} || e.res !== 16'h2143) begin
        failures++;
        $display("FAIL done_hold cyc%0d: got ov=%b ir=%b out=%h expected ov=1 ir=0 out=%h",
                 i, out_valid[0], in_ready[0], obs(0), e);
      end
      in_valid[0] = (i == 1);
      a[0] = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
    end
    finish_op(0);
    checks++;
    if ({out_valid[0], in_ready[0], obs(0)} !== {2'b01, e}) begin
      failures++;
      $display("FAIL done_release: got ov=%b ir=%b out=%h expected ov=0 ir=1 out=%h",
               out_valid[0], in_ready[0], obs(0), e);
    end
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL pulse_ignored: got ir=%b expected 1", in_ready[0]);
    end
  endtask

  task automatic test_reset_midrun();
    int   cyc;
    exp_t e;
    start_op(0, 16'hAAAA, 16'h1111, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid[0], in_ready[0], obs(0)} !== {2'b01, 20'h0}) begin
      failures++;
      $display("FAIL midrun_reset: got ov=%b ir=%b out=%h expected ov=0 ir=1 out=0",
               out_valid[0], in_ready[0], obs(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_done(0, cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc !== 4 || obs(0) !== e || result[0] !== 16'h2345) begin
      failures++;
      $display("FAIL after_reset_op: got lat=%0d out=%h expected lat=4 out=%h", cyc, obs(0), e);
    end
    finish_op(0);
  endtask

  task automatic test_back_to_back();
    int          cyc;
    int          d;
    exp_t        e;
    logic [15:0] x, y;
    for (int i = 0; i < 9; i++) begin
      d = i % 3;
      x = 16'($urandom);
      y = 16'($urandom);
      start_op(d, x, y, 1'($urandom), 1'($urandom));
      wait_done(d, cyc);
      e = exp_q.pop_front();
      checks++;
      if (cyc !== 16 / DIG[d] || obs(d) !== e) begin
        failures++;
        $display("FAIL b2b dut%0d op%0d a=%h b=%h: got lat=%0d out=%h expected lat=%0d out=%h",
                 d, i, x, y, cyc, obs(d), 16 / DIG[d], e);
      end
      finish_op(d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      a[d] = '0; b[d] = '0; sub[d] = 1'b0; sat[d] = 1'b0;
    end
    test_reset();
    test_arith(0);
    test_hold();
    test_reset_midrun();
    test_arith(1);
    test_arith(2);
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0d leftover expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per cycle; WIDTH % DIGIT == 0 and DIGIT >= 1 are required, and an elaboration error SHALL be raised otherwise.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operation request.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port a, input, WIDTH, first operand, two's complement or unsigned.
REQ-008 SHALL have port b, input, WIDTH, second operand.
REQ-009 SHALL have port sub, input, 1, 0 = a+b, 1 = a-b.
REQ-010 SHALL have port sat, input, 1, 1 = signed-saturate result on overflow.
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, consumer takes result.
REQ-013 SHALL have port result, output, WIDTH, final result.
REQ-014 SHALL have port carry, output, 1, carry out of MSB (for sub: 1 = no borrow).
REQ-015 SHALL have ports overflow, zero and negative, each output, 1: signed overflow, result==0, and result MSB respectively.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 exactly when state is IDLE.
REQ-017 SHALL, in IDLE with in_valid=1, capture a, b, sub and sat, preset internal carry to sub, clear the digit counter, and enter RUN on that edge (acceptance edge).
REQ-018 SHALL, in RUN, process one DIGIT-bit slice per cycle, LSB slice first, adding a slice to bitwise-inverted b slice when sub=1, and storing each sum slice and the carry.
REQ-019 SHALL require N = WIDTH/DIGIT RUN cycles; on the edge completing slice N-1 it SHALL enter DONE with out_valid=1, i.e. out_valid is first seen N cycles after the acceptance edge.
REQ-020 SHALL compute overflow = (carry into MSB) XOR (carry out of MSB), and carry = carry out of MSB.
REQ-021 SHALL, when sat=1 and overflow=1, set result to 0 followed by all 1s (max positive) if captured a MSB=0, else to 1 followed by all 0s (min negative); overflow still reports 1.
REQ-022 SHALL derive zero and negative from the final (post-saturation) result.
REQ-023 SHALL hold result and all flags stable in DONE until out_valid and out_ready are both 1, then return to IDLE on that edge; no request is accepted in that same cycle.
REQ-024 SHALL ignore a, b, sub, sat and in_valid changes outside IDLE; throughput is one op per N+2 cycles minimum.
REQ-025 SHALL keep result and flags at their last values in IDLE after a completed transfer, with out_valid=0.

Reset
REQ-026 SHALL, while rst_n=0 (including mid-RUN or in DONE), force state IDLE, out_valid=0, result=0, and carry, overflow, zero and negative all 0, and clear the counter and internal carry; an in-flight op is discarded.
REQ-027 SHALL present in_ready=1 during and after reset, but SHALL accept no request while rst_n=0.

Structure
REQ-028 SHALL place the state enum typedef and the saturation-constant helper functions in shared package addsub_pkg.
REQ-029 SHALL instantiate one sub-module, addsub_slice: a DIGIT-bit combinational ripple slice with inputs x, y, cin and outputs sum, cout, and the carry into its MSB.
REQ-030 SHALL have all registers in seq_addsub clocked by clk and reset by rst_n only.

Verification (WIDTH=16, DIGIT=4 unless noted)
REQ-031 SHALL check 0x7FFF+0x0001, sat=0 -> result 0x8000, overflow=1, carry=0, negative=1, out_valid exactly 4 cycles after acceptance.
REQ-032 SHALL check the same operands with sat=1 -> result 0x7FFF, overflow=1, negative=0; and 0x8000-0x0001 with sat=1 -> 0x8000, overflow=1.
REQ-033 SHALL check 0x0005-0x0005 -> 0x0000, zero=1, carry=1; and 0x0000-0x0001 -> 0xFFFF, carry=0, overflow=0, negative=1.
REQ-034 SHALL check that holding out_ready=0 for 3 cycles in DONE keeps result and flags stable with in_ready=0, that a pulsed in_valid is ignored, and that the op completes on the out_ready=1 edge.
REQ-035 SHALL check that asserting rst_n=0 after 2 RUN cycles makes out_valid=0, in_ready=1 and all outputs 0 immediately, and that a subsequent 0x1234+0x1111 yields 0x2345.
REQ-036 SHALL repeat REQ-031 and REQ-033 with DIGIT=16 (N=1, out_valid 1 cycle after acceptance) and with DIGIT=1 (16 cycles).
